uart_rx_to_mem: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_core.sv | 100 ++++++++++
 rtl/uart_rx_to_mem.sv | 121 ++++++++++++
 tb/tb_uart_rx_to_mem.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encodings, byte order
// and the default bit period.
package uart_pkg;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_WAIT_HI,
        LD_WAIT_LO,
        LD_WRITE,
        LD_DONE
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam bit HI_FIRST             = 1'b1;
    localparam int DEFAULT_CLKS_PER_BIT = 10416;

    // The first byte received on the wire is the high half of the word.
    function automatic logic [15:0] pack_word(input logic [7:0] first,
                                              input logic [7:0] second);
        return HI_FIRST ? {first, second} : {second, first};
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, start-glitch
// rejection and stop-bit check.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       byte_err
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_p0, rx_p1, rx_p2;
    rx_state_t        state, state_nx;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic [7:0]       shreg, shreg_nx;
    logic             valid_nx, err_nx;

    // Stage p0/p1: synchroniser; p2: previous synchronised level for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx_data;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            clk_cnt    <= clk_cnt_nx;
            bit_idx    <= bit_idx_nx;
            shreg      <= shreg_nx;
            byte_valid <= valid_nx;
            byte_err   <= err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clk_cnt_nx = clk_cnt + 1'b1;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        valid_nx   = 1'b0;
        err_nx     = 1'b0;
        unique case (state)
            RX_IDLE: begin
                clk_cnt_nx = '0;
                if (rx_p2 && !rx_p1) state_nx = RX_START;
            end
            RX_START: begin
                // Line back high at half a bit: a glitch, not a start bit.
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_nx = '0;
                    bit_idx_nx = '0;
                    state_nx   = rx_p1 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_nx = '0;
                    shreg_nx   = {rx_p1, shreg[7:1]};
                    bit_idx_nx = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_nx = RX_STOP;
                end
            end
            RX_STOP: begin
                if (clk_cnt == FULL_LAST) begin
                    clk_cnt_nx = '0;
                    valid_nx   = rx_p1;
                    err_nx     = !rx_p1;
                    state_nx   = RX_IDLE;
                end
            end
            default: state_nx = RX_IDLE;
        endcase
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/uart_rx_to_mem.sv
// Serial-to-memory loader: pairs received UART bytes into 16-bit words and
// writes them to consecutive memory addresses after each load_en arm.
module uart_rx_to_mem
    import uart_pkg::*;
#(
    parameter int ROW          = 2,
    parameter int COLUMN       = 2,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_data,
    input  logic        load_en,
    output logic        write,
    output logic [31:0] write_address,
    output logic [15:0] write_value,
    output logic        busy,
    output logic        done,
    output logic        frame_err
);

    localparam int               WORDS     = ROW * COLUMN;
    localparam int               CNT_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(WORDS - 1);

    logic [7:0]       rx_byte;
    logic             byte_valid, byte_err;
    logic             load_en_p0, arm;
    ld_state_t        state, state_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [7:0]       hi_byte, hi_nx;
    logic [15:0]      value_nx;
    logic             ferr_nx;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .byte_err  (byte_err)
    );

    // Stage p0: previous load_en level for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) load_en_p0 <= 1'b0;
        else     load_en_p0 <= load_en;
    end

    assign arm = load_en && !load_en_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LD_IDLE;
            count       <= '0;
            hi_byte     <= '0;
            write_value <= '0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nx;
            count       <= count_nx;
            hi_byte     <= hi_nx;
            write_value <= value_nx;
            frame_err   <= ferr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        hi_nx    = hi_byte;
        value_nx = write_value;
        ferr_nx  = frame_err;
        // Re-arm has priority over any byte event in the same cycle.
        if (arm) begin
            state_nx = LD_WAIT_HI;
            count_nx = '0;
            ferr_nx  = 1'b0;
        end else begin
            unique case (state)
                LD_IDLE: state_nx = LD_IDLE;
                LD_WAIT_HI: begin
                    if (byte_err) begin
                        ferr_nx = 1'b1;
                    end else if (byte_valid) begin
                        hi_nx    = rx_byte;
                        state_nx = LD_WAIT_LO;
                    end
                end
                LD_WAIT_LO: begin
                    // A bad frame discards the half word; the host resends both bytes.
                    if (byte_err) begin
                        ferr_nx  = 1'b1;
                        state_nx = LD_WAIT_HI;
                    end else if (byte_valid) begin
                        value_nx = pack_word(hi_byte, rx_byte);
                        state_nx = LD_WRITE;
                    end
                end
                LD_WRITE: begin
                    if (count == LAST_ADDR) begin
                        state_nx = LD_DONE;
                    end else begin
                        count_nx = count + 1'b1;
                        state_nx = LD_WAIT_HI;
                    end
                end
                LD_DONE: state_nx = LD_IDLE;
                default: state_nx = LD_IDLE;
            endcase
        end
    end

    assign write         = (state == LD_WRITE);
    assign write_address = 32'(count);
    assign busy          = (state == LD_WAIT_HI) || (state == LD_WAIT_LO) || (state == LD_WRITE);
    assign done          = (state == LD_DONE);

endmodule

// File: tb/tb_uart_rx_to_mem.sv
// Self-checking bench for uart_rx_to_mem: directed and random UART loads
// compared against a word-level model of the loader.
module tb_uart_rx_to_mem;

    localparam int ROW    = 2;
    localparam int COLUMN = 2;
    localparam int CPB    = 16;
    localparam int WORDS  = ROW * COLUMN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_data = 1'b1;
    logic        load_en = 1'b0;
    logic        write;
    logic [31:0] write_address;
    logic [15:0] write_value;
    logic        busy, done, frame_err;

    uart_rx_to_mem #(
        .ROW(ROW), .COLUMN(COLUMN), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .load_en(load_en),
        .write(write), .write_address(write_address), .write_value(write_value),
        .busy(busy), .done(done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed activity, sampled on the falling edge
    logic [47:0] got_wr[$];
    int          done_cnt = 0;
    int          done_after_wr = 0;
    int          bv_cnt = 0;
    logic        prev_write = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (write) got_wr.push_back({write_address, write_value});
            if (done) begin
                done_cnt++;
                if (prev_write) done_after_wr++;
            end
            if (dut.byte_valid) bv_cnt++;
        end
        prev_write = write;
    end

    // Word-level reference model
    logic [47:0] exp_wr[$];
    bit          m_armed = 1'b0;
    bit          m_have_hi = 1'b0;
    bit          m_ferr = 1'b0;
    logic [7:0]  m_hi = 8'h00;
    int          m_count = 0;
    int          m_done = 0;

    task automatic m_arm();
        m_armed = 1'b1; m_have_hi = 1'b0; m_count = 0; m_ferr = 1'b0;
    endtask

    task automatic m_reset();
        m_armed = 1'b0; m_have_hi = 1'b0; m_count = 0; m_ferr = 1'b0;
    endtask

    task automatic m_byte(input logic [7:0] b);
        if (m_armed) begin
            if (!m_have_hi) begin
                m_hi = b;
                m_have_hi = 1'b1;
            end else begin
                exp_wr.push_back({32'(m_count), m_hi, b});
                m_have_hi = 1'b0;
                if (m_count == WORDS - 1) begin
                    m_armed = 1'b0;
                    m_done++;
                end else begin
                    m_count++;
                end
            end
        end
    endtask

    task automatic m_bad();
        if (m_armed) begin
            m_ferr = 1'b1;
            m_have_hi = 1'b0;
        end
    endtask

    // Stimulus
    task automatic send_frame(input logic [7:0] b, input bit good);
        rx_data = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_data = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx_data = good;
        repeat (CPB) @(posedge clk);
        rx_data = 1'b1;
        repeat (CPB) @(posedge clk);
        if (good) m_byte(b);
        else      m_bad();
    endtask

    task automatic do_arm();
        load_en = 1'b1;
        repeat (2) @(posedge clk);
        load_en = 1'b0;
        repeat (2) @(posedge clk);
        m_arm();
    endtask

    task automatic glitch();
        int bv_before;
        bv_before = bv_cnt;
        rx_data = 1'b0;
        repeat (8) @(posedge clk);
        rx_data = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        check("glitch_byte_valid", 64'(bv_cnt), 64'(bv_before));
    endtask

    task automatic compare(input string tag);
        logic [63:0] g;
        repeat (4) @(negedge clk);
        check($sformatf("%s_nwrites", tag), 64'(got_wr.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size(); i++) begin
            g = (i < got_wr.size()) ? {16'h0, got_wr[i]} : 64'hDEAD_0000_0000_0000;
            check($sformatf("%s_wr%0d", tag, i), g, {16'h0, exp_wr[i]});
        end
        check($sformatf("%s_busy", tag), 64'(busy), 64'(m_armed));
        check($sformatf("%s_frame_err", tag), 64'(frame_err), 64'(m_ferr));
        check($sformatf("%s_done_cnt", tag), 64'(done_cnt), 64'(m_done));
        check($sformatf("%s_done_after_write", tag), 64'(done_after_wr), 64'(m_done));
        got_wr.delete();
        exp_wr.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s_write", tag), 64'(write), 64'(0));
        check($sformatf("%s_addr", tag), 64'(write_address), 64'(0));
        check($sformatf("%s_value", tag), 64'(write_value), 64'(0));
        check($sformatf("%s_busy", tag), 64'(busy), 64'(0));
        check($sformatf("%s_done", tag), 64'(done), 64'(0));
        check($sformatf("%s_frame_err", tag), 64'(frame_err), 64'(0));
    endtask

    logic [7:0] dir_bytes[8] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07, 8'hFF, 8'hFF};

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Bytes with no arm are ignored
        send_frame(8'h55, 1'b1);
        compare("noarm");

        // Directed full load
        do_arm();
        @(negedge clk);
        check("arm_busy", 64'(busy), 64'(1));
        foreach (dir_bytes[i]) send_frame(dir_bytes[i], 1'b1);
        compare("load1");

        // Bad stop bit after a high byte
        do_arm();
        send_frame(8'h12, 1'b1);
        send_frame(8'h3C, 1'b0);
        @(negedge clk);
        check("err_flag", 64'(frame_err), 64'(1));
        send_frame(8'hAA, 1'b1);
        send_frame(8'hBB, 1'b1);
        compare("err");

        // Re-arm mid-load restarts at address 0 and clears frame_err
        do_arm();
        @(negedge clk);
        check("rearm_ferr_clear", 64'(frame_err), 64'(0));
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        do_arm();
        send_frame(8'h56, 1'b1);
        send_frame(8'h78, 1'b1);
        compare("rearm");

        // Random loads with occasional bad frames and a start-bit glitch
        for (int t = 0; t < 3; t++) begin
            do_arm();
            for (int w = 0; w < WORDS; w++) begin
                if ($urandom_range(0, 3) == 0) send_frame(8'($urandom), 1'b0);
                send_frame(8'($urandom), 1'b1);
                if (w == 1) glitch();
                send_frame(8'($urandom), 1'b1);
            end
            compare($sformatf("rand%0d", t));
        end

        // Reset in the middle of a frame after two words
        do_arm();
        for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1);
        send_frame(8'hC3, 1'b0);
        compare("pre_reset");
        rx_data = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("midframe_reset");
        rx_data = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
        repeat (2 * CPB) @(posedge clk);
        compare("post_reset_idle");
        do_arm();
        for (int i = 0; i < 2 * WORDS; i++) send_frame(8'($urandom), 1'b1);
        compare("post_reset_load");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
